// File: rtl/sha1_nonce_driver.sv
// Nonce search initiator for the sha1 core: streams {nonce, TAIL} blocks, captures each digest
// and compares its top MATCH_BITS against iTarget until a match, the last nonce, or iStop.
//
// state   | meaning
// IDLE    | no search running
// LOAD    | driving block word idx_q to the core
// WAIT    | block sent, waiting for a fresh ready from the core
// CHECK   | compare captured digest prefix, then advance nonce or finish
// DONE    | search finished, result held for the host
module sha1_nonce_driver #(
    parameter int WORD_SIZE   = 32,
    parameter int TOTAL_WORDS = 16,
    parameter int MATCH_BITS  = 24,
    parameter logic [(TOTAL_WORDS-1)*WORD_SIZE-1:0] TAIL =
        480'h4348414C_4C454E47_452D3230_32342D30_312D5348_41312D4E_4F4E4345_2D534541_52434821_21212121_21212121_80000000_00000000_00000000_00000180
) (
    input  logic                 iClk,
    input  logic                 reset,
    input  logic                 iStart,
    input  logic                 iStop,
    input  logic [WORD_SIZE-1:0] iNonceBase,
    input  logic [WORD_SIZE-1:0] iNonceLast,
    input  logic [159:0]         iTarget,
    output logic [WORD_SIZE-1:0] oDat,
    output logic                 oInitial,
    output logic                 oValid,
    input  logic [159:0]         iDigest,
    input  logic                 iReady,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oFound,
    output logic [WORD_SIZE-1:0] oNonce,
    output logic [159:0]         oDigest
);

    localparam int IDX_W = $clog2(TOTAL_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_WORDS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                       state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [WORD_SIZE-1:0]             nonce_q, nonce_d;
    logic                             seen_low_q, seen_low_d;
    logic                             found_q, found_d;
    logic [WORD_SIZE-1:0]             nonce_out_q, nonce_out_d;
    logic [159:0]                     digest_q, digest_d;
    logic [WORD_SIZE-1:0]             dat_q, dat_d;
    logic                             initial_q, initial_d;
    logic                             valid_q, valid_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    logic                             match;
    logic [TOTAL_WORDS*WORD_SIZE-1:0] block;

    assign match = digest_q[159 -: MATCH_BITS] == iTarget[159 -: MATCH_BITS];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        nonce_d     = nonce_q;
        found_d     = found_q;
        nonce_out_d = nonce_out_q;
        digest_d    = digest_q;
        seen_low_d  = seen_low_q | ~iReady;

        if (iStop) begin
            state_d = S_IDLE;
            found_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (iStart) begin
                        state_d = S_LOAD;
                        nonce_d = iNonceBase;
                        idx_d   = '0;
                        found_d = 1'b0;
                    end
                end
                S_LOAD: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_WAIT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                S_WAIT: begin
                    // a ready still high from the previous block must first drop
                    if (iReady && seen_low_q) begin
                        digest_d    = iDigest;
                        nonce_out_d = nonce_q;
                        state_d     = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (match) begin
                        found_d = 1'b1;
                        state_d = S_DONE;
                    end else if (nonce_q == iNonceLast) begin
                        found_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        nonce_d = nonce_q + WORD_SIZE'(1);
                        idx_d   = '0;
                        state_d = S_LOAD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d == S_LOAD && state_q != S_LOAD) begin
            seen_low_d = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    assign block = {nonce_d, TAIL};

    always_comb begin
        dat_d = '0;
        if (state_d == S_LOAD) begin
            for (int j = 0; j < TOTAL_WORDS; j++) begin
                if (idx_d == IDX_W'(j)) begin
                    dat_d = block[(TOTAL_WORDS-1-j)*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
        valid_d   = state_d == S_LOAD;
        initial_d = (state_d == S_LOAD) && (idx_d == '0);
        busy_d    = (state_d == S_LOAD) || (state_d == S_WAIT) || (state_d == S_CHECK);
        done_d    = state_d == S_DONE;
    end

    always_ff @(posedge iClk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            nonce_q     <= '0;
            seen_low_q  <= 1'b0;
            found_q     <= 1'b0;
            nonce_out_q <= '0;
            digest_q    <= '0;
            dat_q       <= '0;
            initial_q   <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            nonce_q     <= nonce_d;
            seen_low_q  <= seen_low_d;
            found_q     <= found_d;
            nonce_out_q <= nonce_out_d;
            digest_q    <= digest_d;
            dat_q       <= dat_d;
            initial_q   <= initial_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign oDat     = dat_q;
    assign oInitial = initial_q;
    assign oValid   = valid_q;
    assign oBusy    = busy_q;
    assign oDone    = done_q;
    assign oFound   = found_q;
    assign oNonce   = nonce_out_q;
    assign oDigest  = digest_q;

    generate
        if (MATCH_BITS < 160) begin : g_unused_target
            logic unused_target;
            assign unused_target = ^iTarget[159-MATCH_BITS:0];
        end
    endgenerate

endmodule
